// File: rtl/ascon_pkg.sv
// ascon_pkg: shared definitions for the LUT-based Ascon-p round and its S-box loader.
//   SBOX_W / SBOX_DEPTH  : S-box entry width and table depth (5-bit S-box, 32 entries)
//   loader_state_t       : state encoding of the S-box loader FSM
//   ASCON_SBOX           : default Ascon S-box, S[x] for x = 0..31
package ascon_pkg;

  localparam int SBOX_W     = 5;
  localparam int SBOX_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LOAD,
    ST_FINISH
  } loader_state_t;

  localparam logic [SBOX_W-1:0] ASCON_SBOX [SBOX_DEPTH] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

endpackage

// File: rtl/ascon_sbox_loader_if.sv
// ascon_sbox_loader_if: entry stream from the host/config path plus the LUT update port.
//   entry_valid_i / entry_ready_o / entry_data_i : host -> loader valid/ready stream
//   upd_sbox_o / sbox_addr_o / sbox_new_data_o   : loader -> LUT write port
// Modports:
//   master : the loader (consumes the stream, drives the LUT write port)
//   slave  : host + LUT side
interface ascon_sbox_loader_if #(
  parameter int NUM_BANKS = 4
);
  import ascon_pkg::*;

  logic                          entry_valid_i;
  logic                          entry_ready_o;
  logic [SBOX_W-1:0]             entry_data_i;
  logic                          upd_sbox_o;
  logic [SBOX_W-1:0]             sbox_addr_o;
  logic [SBOX_W*NUM_BANKS-1:0]   sbox_new_data_o;

  modport master (
    input  entry_valid_i, entry_data_i,
    output entry_ready_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );

  modport slave (
    output entry_valid_i, entry_data_i,
    input  entry_ready_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );

endinterface

// File: rtl/ascon_sbox_loader.sv
// ascon_sbox_loader: write-side master for the programmable S-box LUT of the Ascon-p round.
// Takes SBOX_ENTRIES five-bit entries (address order) over a valid/ready stream and issues
// one LUT write per accepted entry, one cycle after the handshake, with the entry replicated
// across NUM_BANKS banks. The permutation controller is held off from the cycle after
// start_i until the load has finished.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : single-cycle load request (ignored unless idle)
//   perm_busy_i  : permutation core is computing rounds
//   perm_hold_o  : forbids the controller from starting a permutation
//   busy_o       : load in progress
//   done_o       : one-cycle pulse, load complete
//   err_o        : table not a bijection (duplicate entry seen), valid with done_o
//   sbox         : entry stream + LUT write port (ascon_sbox_loader_if.master)
// Build option:
//   ASCON_SBOX_BIJ_CHECK_EN : enables the duplicate-entry checker behind err_o;
//                             when undefined err_o is tied low.
module ascon_sbox_loader
  import ascon_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int SBOX_ENTRIES = SBOX_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       perm_busy_i,
  output logic                       perm_hold_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  ascon_sbox_loader_if.master        sbox
);

  localparam logic [SBOX_W-1:0] LAST_ADDR = SBOX_W'(SBOX_ENTRIES - 1);

  loader_state_t     state;
  logic [SBOX_W-1:0] cnt;
  logic              hs;
  logic              start_acc;

  // A round in flight must never see the table change, so entries are only taken while
  // the core is quiet; a busy core during LOAD just stalls the stream.
  assign sbox.entry_ready_o = (state == ST_LOAD) && !perm_busy_i;
  assign hs                 = sbox.entry_valid_i && sbox.entry_ready_o;
  assign start_acc          = (state == ST_IDLE) && start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      busy_o               <= 1'b0;
      perm_hold_o          <= 1'b0;
      done_o               <= 1'b0;
      sbox.upd_sbox_o      <= 1'b0;
      sbox.sbox_addr_o     <= '0;
      sbox.sbox_new_data_o <= '0;
    end else begin
      sbox.upd_sbox_o <= 1'b0;
      done_o          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state       <= ST_DRAIN;
            busy_o      <= 1'b1;
            perm_hold_o <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!perm_busy_i) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // write stage: address/data hold their last values between writes
          if (hs) begin
            sbox.upd_sbox_o      <= 1'b1;
            sbox.sbox_addr_o     <= cnt;
            sbox.sbox_new_data_o <= {NUM_BANKS{sbox.entry_data_i}};
            if (cnt == LAST_ADDR) begin
              cnt   <= '0;
              state <= ST_FINISH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FINISH: begin
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          perm_hold_o <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ASCON_SBOX_BIJ_CHECK_EN
  logic [SBOX_DEPTH-1:0] seen;
  logic                  dup;

  // Any value accepted twice means some other value is missing: the table is not a
  // permutation. The writes still go out; software decides what to do with err_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen  <= '0;
      dup   <= 1'b0;
      err_o <= 1'b0;
    end else if (start_acc) begin
      seen  <= '0;
      dup   <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (hs) begin
        seen[sbox.entry_data_i] <= 1'b1;
        if (seen[sbox.entry_data_i]) dup <= 1'b1;
      end
      if (state == ST_FINISH) err_o <= dup;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_sbox_loader.sv
// tb_ascon_sbox_loader: directed bench for the S-box loader (nominal load, drain,
// backpressure, reset mid-load, ignored starts, duplicate-entry flag).
module tb_ascon_sbox_loader;
  import ascon_pkg::*;

  localparam int NB = 4;
`ifdef ASCON_SBOX_BIJ_CHECK_EN
  localparam logic BIJ = 1'b1;
`else
  localparam logic BIJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start_i, perm_busy_i;
  logic perm_hold_o, busy_o, done_o, err_o;

  ascon_sbox_loader_if #(.NUM_BANKS(NB)) sbox_if ();

  ascon_sbox_loader #(.NUM_BANKS(NB), .SBOX_ENTRIES(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .perm_busy_i (perm_busy_i),
    .perm_hold_o (perm_hold_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .sbox        (sbox_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // write monitor, sampled on the falling edge
  int          cyc = 0;
  int          wr_cnt = 0, done_cnt = 0, seq_err = 0, rep_err = 0;
  int          wr_last_cyc = -10, done_cyc = -20;
  logic        err_at_done = 1'b0;
  logic [4:0]  exp_addr = 5'd0;
  logic [19:0] lut_data [32];
  logic [4:0]  tbl [32];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_addr <= 5'd0;
    end else begin
      if (sbox_if.upd_sbox_o) begin
        wr_cnt <= wr_cnt + 1;
        if (sbox_if.sbox_addr_o !== exp_addr) seq_err <= seq_err + 1;
        if (sbox_if.sbox_new_data_o !== {4{sbox_if.sbox_new_data_o[4:0]}}) rep_err <= rep_err + 1;
        lut_data[sbox_if.sbox_addr_o] <= sbox_if.sbox_new_data_o;
        exp_addr <= exp_addr + 5'd1;
        if (sbox_if.sbox_addr_o == 5'd31) wr_last_cyc <= cyc;
      end
      if (done_o) begin
        done_cnt    <= done_cnt + 1;
        done_cyc    <= cyc;
        err_at_done <= err_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("hold_after_start", 32'(perm_hold_o), 32'd1);
  endtask

  // Streams tbl[0..n-1]; optional valid gaps, perm_busy pulses, a start pulse while
  // entry restart_at is pending, and a start pulse in the FINISH cycle.
  task automatic stream(input int gap, input int stall, input int n,
                        input int restart_at, input int finish_start);
    int   i = 0;
    int   budget = 0;
    logic hs;
    while (i < n && budget < 3000) begin
      sbox_if.entry_valid_i = (gap != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      sbox_if.entry_data_i  = tbl[i];
      perm_busy_i           = (stall != 0) ? ($urandom_range(0, 4) == 0) : 1'b0;
      start_i               = (i == restart_at);
      @(negedge clk);
      hs = sbox_if.entry_valid_i && sbox_if.entry_ready_o;
      tick();
      if (hs) i++;
      budget++;
    end
    sbox_if.entry_valid_i = 1'b0;
    perm_busy_i           = 1'b0;
    start_i               = 1'b0;
    if (budget >= 3000) chk("stream_timeout", 32'(i), 32'(n));
    if (finish_start != 0 && i == n) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic chk_lut(input string tag);
    int m = 0;
    for (int i = 0; i < 32; i++)
      if (lut_data[i] !== {4{tbl[i]}}) m++;
    chk(tag, 32'(m), 32'd0);
  endtask

  int w0, d0;

  initial begin
    rst                   = 1'b1;
    start_i               = 1'b0;
    perm_busy_i           = 1'b0;
    sbox_if.entry_valid_i = 1'b0;
    sbox_if.entry_data_i  = 5'd0;
    repeat (3) tick();
    chk("rst_upd",   32'(sbox_if.upd_sbox_o), 32'd0);
    chk("rst_addr",  32'(sbox_if.sbox_addr_o), 32'd0);
    chk("rst_data",  32'(sbox_if.sbox_new_data_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_hold",  32'(perm_hold_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    rst = 1'b0;
    tick();

    // nominal load of the Ascon table
    for (int i = 0; i < 32; i++) tbl[i] = ASCON_SBOX[i];
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    stream(0, 0, 32, -1, 0);
    wait_done(d0);
    chk("nom_writes", 32'(wr_cnt - w0), 32'd32);
    chk("nom_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("nom_done_lat", 32'(done_cyc - wr_last_cyc), 32'd1);
    chk("nom_addr0", 32'(lut_data[0]), 32'h21084);
    chk("nom_addr2", 32'(lut_data[2]), 32'hFFFFF);
    chk("nom_addr31", 32'(lut_data[31]), 32'hBDEF7);
    chk("nom_err", 32'(err_at_done), 32'd0);
    chk("nom_busy_end", 32'(busy_o), 32'd0);
    chk("nom_hold_end", 32'(perm_hold_o), 32'd0);
    chk_lut("nom_lut");

    // drain: core busy for 10 cycles after start, host already offering entry 0
    w0 = wr_cnt; d0 = done_cnt;
    perm_busy_i = 1'b1;
    sbox_if.entry_valid_i = 1'b1;
    sbox_if.entry_data_i  = tbl[0];
    do_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("drain_hold", 32'(perm_hold_o), 32'd1);
      chk("drain_ready", 32'(sbox_if.entry_ready_o), 32'd0);
    end
    chk("drain_no_wr", 32'(wr_cnt - w0), 32'd0);
    stream(0, 0, 32, -1, 0);
    wait_done(d0);
    chk("drain_writes", 32'(wr_cnt - w0), 32'd32);
    chk_lut("drain_lut");

    // backpressure: reversed table, random valid gaps and perm_busy pulses
    for (int i = 0; i < 32; i++) tbl[i] = ASCON_SBOX[31 - i];
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    stream(1, 1, 32, -1, 0);
    wait_done(d0);
    chk("bp_writes", 32'(wr_cnt - w0), 32'd32);
    chk("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk_lut("bp_lut");

    // reset after 12 entries
    for (int i = 0; i < 32; i++) tbl[i] = ASCON_SBOX[i];
    do_start();
    stream(0, 0, 12, -1, 0);
    sbox_if.entry_valid_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_upd",   32'(sbox_if.upd_sbox_o), 32'd0);
    chk("mid_rst_addr",  32'(sbox_if.sbox_addr_o), 32'd0);
    chk("mid_rst_data",  32'(sbox_if.sbox_new_data_o), 32'd0);
    chk("mid_rst_busy",  32'(busy_o), 32'd0);
    chk("mid_rst_hold",  32'(perm_hold_o), 32'd0);
    chk("mid_rst_ready", 32'(sbox_if.entry_ready_o), 32'd0);
    w0 = wr_cnt;
    repeat (3) tick();
    chk("mid_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    rst = 1'b0;
    sbox_if.entry_valid_i = 1'b0;
    tick();
    chk("post_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    stream(0, 0, 32, -1, 0);
    wait_done(d0);
    chk("reload_writes", 32'(wr_cnt - w0), 32'd32);
    chk_lut("reload_lut");

    // start pulses at entry 5 and in the FINISH cycle are ignored
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    stream(0, 0, 32, 5, 1);
    wait_done(d0);
    repeat (6) tick();
    chk("ign_writes", 32'(wr_cnt - w0), 32'd32);
    chk("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ign_busy", 32'(busy_o), 32'd0);
    chk("ign_hold", 32'(perm_hold_o), 32'd0);

    // identity table with entry 7 replaced by 3
    for (int i = 0; i < 32; i++) tbl[i] = 5'(i);
    tbl[7] = 5'd3;
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    stream(0, 0, 32, -1, 0);
    wait_done(d0);
    chk("dup_err_at_done", 32'(err_at_done), 32'(BIJ));
    repeat (4) tick();
    chk("dup_err_held", 32'(err_o), 32'(BIJ));
    chk("dup_writes", 32'(wr_cnt - w0), 32'd32);
    chk_lut("dup_lut");
    tbl[7] = 5'd7;
    d0 = done_cnt;
    do_start();
    chk("err_clr_on_start", 32'(err_o), 32'd0);
    stream(0, 0, 32, -1, 0);
    wait_done(d0);
    chk("ident_err", 32'(err_at_done), 32'd0);
    chk_lut("ident_lut");

    chk("addr_sequence_errs", 32'(seq_err), 32'd0);
    chk("replication_errs", 32'(rep_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_sbox_loader.md
Name: ascon_sbox_loader

Overview:
- Write-side master for the programmable S-box LUT inside the LUT-based Ascon-p round.
- Accepts 32 five-bit S-box entries from the host/config path over a valid/ready stream and drives the LUT update port (upd/addr/data) with one write per entry.
- Holds off the permutation controller while a table load is in progress.
- Sits between the register/config interface and the permutation core.

Parameters:
- NUM_BANKS, 4, number of parallel LUT banks; each written word carries the entry replicated NUM_BANKS times.
- SBOX_ENTRIES, 32, table depth (fixed by the 5-bit S-box; must equal 2**5).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  request a new table load (single-cycle pulse)
- entry_valid_i  in  1  host entry valid
- entry_ready_o  out  1  loader accepts entry
- entry_data_i  in  5  S-box output value S[addr], entries in address order 0..31
- perm_busy_i  in  1  permutation core currently computing rounds
- perm_hold_o  out  1  forbids the controller from starting a permutation
- upd_sbox_o  out  1  LUT write strobe
- sbox_addr_o  out  5  LUT write address
- sbox_new_data_o  out  5*NUM_BANKS  LUT write data, {NUM_BANKS{entry}}
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse, load complete
- err_o  out  1  table-invalid flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; address counter 0. The reset is asynchronous, and a reset mid-load abandons the load without issuing a further write. The LUT is left partially written; software must reload.
- FSM states: IDLE, DRAIN, LOAD, FINISH.
- IDLE:
  - start_i -> DRAIN.
  - busy_o and perm_hold_o are asserted from the cycle after start_i.
- DRAIN:
  - Waits while perm_busy_i=1, so a round in flight is never disturbed.
  - perm_busy_i=0 -> LOAD.
- LOAD:
  - entry_ready_o = !perm_busy_i (combinational, within LOAD only).
  - On each handshake (entry_valid_i & entry_ready_o), the next cycle registers upd_sbox_o=1, sbox_addr_o=counter, sbox_new_data_o=replicated entry_data_i. The counter then increments.
  - Write latency is exactly 1 cycle after the handshake. upd_sbox_o is 0 in every non-handshake cycle, and addr/data hold their last values.
  - Handshake at counter=31 -> FINISH. The counter wraps to 0.
- FINISH (1 cycle):
  - done_o=1.
  - busy_o and perm_hold_o deassert in the following cycle -> IDLE.
- Host-side behaviour:
  - Back-to-back entries are allowed: one write per cycle, full throughput.
  - entry_valid_i outside LOAD is ignored (ready=0).
  - start_i while busy is ignored; no restart.
  - start_i in the FINISH cycle is also ignored.
- perm_busy_i rising during LOAD is a controller protocol violation. The loader only stalls (ready=0); it does not abort.
- perm_hold_o stays high continuously from DRAIN through FINISH.

Optional Feature:
- Macro ASCON_SBOX_BIJ_CHECK_EN.
- Defined:
  - A 32-bit seen-mask register is cleared on start and sets bit entry_data_i on each handshake.
  - If an accepted value's bit is already set, a sticky duplicate flag is raised.
  - err_o is registered in the FINISH cycle (valid with done_o) and held until the next start_i or reset.
  - The writes themselves still occur.
- Undefined: err_o is tied 0 and no mask logic is present.

Decomposition:
- Shared package ascon_pkg:
  - SBOX_W=5 and SBOX_DEPTH=32.
  - Loader state enum typedef.
  - Default Ascon S-box constant array, used by benches and future default-load logic.
- Sub-module: none needed. The optional bijection checker is kept inline under the macro.

Test Plan:
- Nominal load: reset, start_i, stream the Ascon table 04,0b,1f,14,1a,15,09,02,1b,05,08,12,1d,03,06,1c,1e,13,07,0e,00,0d,11,18,10,0c,01,19,16,0a,0f,17 with valid held high. Expect:
  - 32 consecutive writes, addr 0..31.
  - addr 2 data 0xFFFFF (0x1f replicated).
  - done_o exactly 1 cycle after the addr-31 write cycle.
  - err_o=0.
- Drain: perm_busy_i=1 for 10 cycles after start_i. Expect:
  - perm_hold_o=1 throughout.
  - entry_ready_o=0 until perm_busy_i falls; first write at addr 0 only after that.
- Backpressure/gaps: toggle entry_valid_i randomly and pulse perm_busy_i during LOAD. Expect:
  - Writes only on handshakes; no address skipped or repeated.
  - Final LUT model matches the sent table.
- Reset mid-load: assert rst after 12 entries. Expect:
  - All outputs 0 immediately (async), no further upd_sbox_o.
  - A subsequent full load succeeds from addr 0.
- Ignored start: pulse start_i at entry 5 and in the FINISH cycle. Expect no restart, a single done_o, and an exact total of 32 writes.
- Duplicate check (ASCON_SBOX_BIJ_CHECK_EN defined): send the identity table with entry 7 replaced by 3. Expect:
  - err_o=1 with done_o, held until the next start_i.
  - An identity reload clears it (err_o=0).
